// File: rtl/ref_pot_pkg.sv
// ref_pot_pkg: shared types and default calibration for the REF-to-POT scaler.
// Holds the FSM state enum, the default servo calibration and the STATUS bit
// positions used by ref_pot_scaler and its consumers.
package ref_pot_pkg;

    // Control FSM states of the scaler.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MULT  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Default servo calibration: OUT = sat(round((CENTER - REF) * GAIN / 2^FRAC)).
    localparam int DEF_CENTER  = 180;
    localparam int DEF_GAIN    = 181;   // 181/256 ~ 0.707
    localparam int DEF_FRAC    = 8;
    localparam int DEF_REF_MIN = 20;
    localparam int DEF_REF_MAX = 340;

    // STATUS bit positions.
    localparam int STATUS_SAT_BIT   = 0;
    localparam int STATUS_RANGE_BIT = 1;

endpackage : ref_pot_pkg

// File: rtl/ref_pot_serial_mult.sv
// ref_pot_serial_mult: signed-by-unsigned shift-add multiplier.
// A load pulse captures a signed multiplicand and an unsigned multiplier; one
// multiplier bit (LSB first) is consumed per cycle. 'done' is high during the
// cycle in which the last partial product is accumulated, so 'product' holds
// the final value from the following cycle onward until the next load.
module ref_pot_serial_mult #(
    parameter int MC_W  = 10,              // signed multiplicand width
    parameter int MP_W  = 8,               // unsigned multiplier width
    parameter int ACC_W = MC_W + MP_W      // signed product width
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic signed [MC_W-1:0]  mcand,
    input  logic        [MP_W-1:0]  mplier,
    output logic                    busy,
    output logic                    done,
    output logic signed [ACC_W-1:0] product
);

    localparam int CNT_W = (MP_W > 1) ? $clog2(MP_W) : 1;
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(MP_W - 1);

    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] mcand_r;
    logic        [MP_W-1:0]  mplier_r;
    logic        [CNT_W-1:0] cnt_r;
    logic                    busy_r;

    // Shift-add datapath: load operands, then add the shifted multiplicand for each set multiplier bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
        end else if (load) begin
            acc_r    <= '0;
            mcand_r  <= {{(ACC_W - MC_W){mcand[MC_W-1]}}, mcand};
            mplier_r <= mplier;
            cnt_r    <= '0;
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            if (mplier_r[0]) begin
                acc_r <= acc_r + mcand_r;
            end
            mcand_r  <= mcand_r <<< 1;
            mplier_r <= mplier_r >> 1;
            if (cnt_r == LAST_C) begin
                busy_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Status decode: 'done' flags the final accumulation step.
    always_comb begin
        busy    = busy_r;
        done    = busy_r && (cnt_r == LAST_C);
        product = acc_r;
    end

endmodule : ref_pot_serial_mult

// File: rtl/ref_pot_scaler.sv
// ref_pot_scaler: handshaked REF-to-POT setpoint scaler.
// Computes OUT = sat(round((CENTER - REF) * GAIN / 2^FRAC)) with a serial
// multiplier, tagging each result with the request's channel. Requests with
// REF outside [REF_MIN, REF_MAX] still take the full, constant latency and
// produce OUT = 0.
// Optional feature: define REF_POT_STATUS_EN to build the STATUS flag
// registers (saturated / out-of-range); otherwise STATUS is tied to 2'b00.
module ref_pot_scaler
    import ref_pot_pkg::*;
#(
    parameter int IN_W    = 9,
    parameter int OUT_W   = 8,
    parameter int GAIN_W  = 8,
    parameter int FRAC    = DEF_FRAC,
    parameter int CENTER  = DEF_CENTER,
    parameter int GAIN    = DEF_GAIN,
    parameter int REF_MIN = DEF_REF_MIN,
    parameter int REF_MAX = DEF_REF_MAX,
    parameter int CH_W    = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [IN_W-1:0]   IN_REF,
    input  logic [CH_W-1:0]   IN_CH,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [OUT_W-1:0]  OUT,
    output logic [CH_W-1:0]   OUT_CH,
    output logic [1:0]        STATUS
);

    localparam int DIFF_W = IN_W + 1;
    localparam int ACC_W  = IN_W + GAIN_W + 1;

    localparam logic        [IN_W-1:0]   REF_MIN_C = IN_W'(REF_MIN);
    localparam logic        [IN_W-1:0]   REF_MAX_C = IN_W'(REF_MAX);
    localparam logic signed [DIFF_W-1:0] CENTER_C  = DIFF_W'(CENTER);
    localparam logic        [GAIN_W-1:0] GAIN_C    = GAIN_W'(GAIN);
    localparam logic signed [ACC_W:0]    BIAS_C    = (ACC_W + 1)'(2 ** (FRAC - 1));
    localparam logic signed [ACC_W:0]    OUT_MAX_C = (ACC_W + 1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0]    OUT_MIN_C = (ACC_W + 1)'(-(2 ** (OUT_W - 1)));

    state_t                  state_r;
    logic [CH_W-1:0]         ch_r;
    logic                    range_r;
    logic [OUT_W-1:0]        out_r;
    logic [CH_W-1:0]         out_ch_r;
    logic                    out_valid_r;

    logic signed [DIFF_W-1:0] diff_s;
    logic                     range_in_s;
    logic                     load_s;
    logic                     mult_busy_s;
    logic                     mult_done_s;
    logic signed [ACC_W-1:0]  mult_product_s;
    logic signed [ACC_W:0]    round_s;
    logic [OUT_W-1:0]         clamp_s;

`ifdef REF_POT_STATUS_EN
    logic                     sat_s;
    logic [1:0]               status_r;
`endif

    // Request decode: signed offset from center, legal-range test and multiplier load strobe.
    always_comb begin
        diff_s     = CENTER_C - $signed({1'b0, IN_REF});
        range_in_s = (IN_REF < REF_MIN_C) || (IN_REF > REF_MAX_C);
        load_s     = (state_r == ST_IDLE) && IN_VALID;
    end

    ref_pot_serial_mult #(
        .MC_W  (DIFF_W),
        .MP_W  (GAIN_W),
        .ACC_W (ACC_W)
    ) u_mult (
        .clk     (CLK),
        .rst_n   (RST_N),
        .load    (load_s),
        .mcand   (diff_s),
        .mplier  (GAIN_C),
        .busy    (mult_busy_s),
        .done    (mult_done_s),
        .product (mult_product_s)
    );

    // Round half-up (arithmetic shift floors after the bias) and clamp to the OUT range.
    always_comb begin
        round_s = ($signed({mult_product_s[ACC_W-1], mult_product_s}) + BIAS_C) >>> FRAC;
        if (round_s > OUT_MAX_C) begin
            clamp_s = OUT_MAX_C[OUT_W-1:0];
        end else if (round_s < OUT_MIN_C) begin
            clamp_s = OUT_MIN_C[OUT_W-1:0];
        end else begin
            clamp_s = round_s[OUT_W-1:0];
        end
    end

`ifdef REF_POT_STATUS_EN
    // Saturation flag: the clamp changed the rounded value.
    always_comb begin
        sat_s = (round_s > OUT_MAX_C) || (round_s < OUT_MIN_C);
    end
`endif

    // Control FSM with registered result, tag, status and valid.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            ch_r        <= '0;
            range_r     <= 1'b0;
            out_r       <= '0;
            out_ch_r    <= '0;
            out_valid_r <= 1'b0;
`ifdef REF_POT_STATUS_EN
            status_r    <= 2'b00;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        ch_r    <= IN_CH;
                        range_r <= range_in_s;
                        state_r <= ST_MULT;
                    end
                end
                ST_MULT: begin
                    if (mult_busy_s && mult_done_s) begin
                        state_r <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    out_r       <= range_r ? {OUT_W{1'b0}} : clamp_s;
                    out_ch_r    <= ch_r;
                    out_valid_r <= 1'b1;
`ifdef REF_POT_STATUS_EN
                    status_r[STATUS_SAT_BIT]   <= sat_s && !range_r;
                    status_r[STATUS_RANGE_BIT] <= range_r;
`endif
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    if (OUT_READY) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Output drive: ready decoded from the state register, everything else registered.
    always_comb begin
        IN_READY  = (state_r == ST_IDLE);
        OUT_VALID = out_valid_r;
        OUT       = out_r;
        OUT_CH    = out_ch_r;
`ifdef REF_POT_STATUS_EN
        STATUS    = status_r;
`else
        STATUS    = 2'b00;
`endif
    end

endmodule : ref_pot_scaler

// File: tb/tb_ref_pot_scaler.sv
// tb_ref_pot_scaler: self-checking bench for ref_pot_scaler.
// Two instances share the request stream: one with the default gain (181) and
// one with gain 255 to reach saturation. Expected results come from an
// integer-arithmetic reference model of the scaling formula.
module tb_ref_pot_scaler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [8:0] in_ref;
    logic [1:0] in_ch;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [7:0] out_a, out_b;
    logic [1:0] och_a, och_b, st_a, st_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ref_pot_scaler dut (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready_a),
        .IN_REF(in_ref), .IN_CH(in_ch), .OUT_VALID(out_valid_a), .OUT_READY(out_ready),
        .OUT(out_a), .OUT_CH(och_a), .STATUS(st_a)
    );

    ref_pot_scaler #(.GAIN(255)) dut_hi (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready_b),
        .IN_REF(in_ref), .IN_CH(in_ch), .OUT_VALID(out_valid_b), .OUT_READY(out_ready),
        .OUT(out_b), .OUT_CH(och_b), .STATUS(st_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: round((180 - r) * g / 256), rounding half up (floor after +128).
    function automatic int model_raw(input int r, input int g);
        int v;
        v = (180 - r) * g + 128;
        if (v >= 0) return v / 256;
        return -((-v + 255) / 256);
    endfunction

    function automatic bit model_oor(input int r);
        return (r < 20) || (r > 340);
    endfunction

    function automatic logic [7:0] model_out(input int r, input int g);
        int x;
        if (model_oor(r)) return 8'h00;
        x = model_raw(r, g);
        if (x > 127)  x = 127;
        if (x < -128) x = -128;
        return 8'(x);
    endfunction

    function automatic logic [1:0] model_status(input int r, input int g);
        logic [1:0] s;
        int x;
        s = 2'b00;
`ifdef REF_POT_STATUS_EN
        x = model_raw(r, g);
        s[1] = model_oor(r);
        s[0] = !model_oor(r) && ((x > 127) || (x < -128));
`else
        x = 0;
`endif
        return s;
    endfunction

    // One request/response; 'stall' cycles of OUT_READY low in DONE before the handshake.
    task automatic txn(input int r, input int c, input int stall);
        logic [7:0] ea, eb;
        logic [1:0] sa, sb;
        int lat;
        bit seen;
        ea = model_out(r, 181);
        eb = model_out(r, 255);
        sa = model_status(r, 181);
        sb = model_status(r, 255);
        @(negedge clk);
        check_eq("in_ready_idle", 32'(in_ready_a), 32'd1);
        in_valid  = 1'b1;
        in_ref    = 9'(r);
        in_ch     = 2'(c);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_ref   = 9'($urandom);
        in_ch    = 2'($urandom);
        lat  = 0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid_a) seen = 1'b1;
        end
        check_eq("latency", 32'(lat), 32'd9);
        check_eq("out", 32'(out_a), 32'(ea));
        check_eq("out_ch", 32'(och_a), 32'(c));
        check_eq("status", 32'(st_a), 32'(sa));
        check_eq("hi_valid", 32'(out_valid_b), 32'd1);
        check_eq("hi_out", 32'(out_b), 32'(eb));
        check_eq("hi_out_ch", 32'(och_b), 32'(c));
        check_eq("hi_status", 32'(st_b), 32'(sb));
        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            #1;
            check_eq("stall_out", 32'(out_a), 32'(ea));
            check_eq("stall_valid", 32'(out_valid_a), 32'd1);
            check_eq("stall_ch", 32'(och_a), 32'(c));
            check_eq("stall_ready", 32'(in_ready_a), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_hs_valid", 32'(out_valid_a), 32'd0);
        check_eq("post_hs_ready", 32'(in_ready_a), 32'd1);
        check_eq("hi_post_hs_valid", 32'(out_valid_b), 32'd0);
        out_ready = 1'b0;
    endtask

    // Safety net against a hung handshake.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_ref    = 9'd0;
        in_ch     = 2'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_out", 32'(out_a), 32'd0);
        check_eq("rst_valid", 32'(out_valid_a), 32'd0);
        check_eq("rst_ch", 32'(och_a), 32'd0);
        check_eq("rst_status", 32'(st_a), 32'd0);
        check_eq("rst_ready", 32'(in_ready_a), 32'd1);

        // Directed points: nominal, center, far end, mid, out-of-range, long stall.
        txn(20, 0, 0);
        txn(180, 1, 0);
        txn(340, 3, 0);
        txn(100, 3, 0);
        txn(10, 2, 0);
        txn(400, 1, 0);
        txn(20, 2, 20);

        // Randomized requests across the full REF code space.
        for (int i = 0; i < 30; i++) begin
            txn(int'($urandom_range(0, 511)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Asynchronous reset in the middle of a multiply, with a prior result held on OUT.
        txn(100, 3, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_ref   = 9'd340;
        in_ch    = 2'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("abort_out", 32'(out_a), 32'd0);
        check_eq("abort_ch", 32'(och_a), 32'd0);
        check_eq("abort_status", 32'(st_a), 32'd0);
        check_eq("abort_valid", 32'(out_valid_a), 32'd0);
        check_eq("abort_hi_out", 32'(out_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        txn(60, 2, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ref_pot_scaler
